// File: rtl/video_cfg_ctrl.sv
// Configuration frame decoder for runtime video/audio settings. Scanline and offset
// writes land in shadow registers and commit on vsync start; volume ramps one step per fade tick.
module video_cfg_ctrl #(
    parameter logic [7:0] CMD_SCAN   = 8'h50,
    parameter logic [7:0] CMD_VOL    = 8'h51,
    parameter logic [7:0] CMD_HOFF   = 8'h52,
    parameter int         FADE_DIV   = 32000,
    parameter logic [1:0] VOL_RESET  = 2'd2,
    parameter logic [9:0] HOFF_RESET = 10'd70
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       mcu_start,
    input  logic       mcu_strobe,
    input  logic [7:0] mcu_data,
    input  logic       vs_n,
    output logic [1:0] scanlines,
    output logic [1:0] volume,
    output logic [9:0] h_offset,
    output logic       busy,
    output logic       cmd_err
);

    localparam int CW = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [CW-1:0] FADE_LAST = CW'(FADE_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_PAY0, S_PAY1} state_t;
    typedef enum logic [1:0] {K_SCAN, K_VOL, K_HOFF, K_NONE} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    kind_t         cmd_kind;
    logic [7:0]    hoff_lo_q;
    logic [1:0]    scan_shadow_q;
    logic [9:0]    hoff_shadow_q;
    logic [1:0]    vol_tgt_q;
    logic          pending_q;
    logic          vs_prev_q;
    logic [CW-1:0] fade_cnt_q;
    logic [1:0]    scanlines_q;
    logic [1:0]    volume_q;
    logic [9:0]    h_offset_q;
    logic          cmd_err_q;

    logic scan_wr, vol_wr, hoff_lo_wr, hoff_wr, bad_cmd;
    logic vs_fall, fade_tick;

    assign vs_fall   = vs_prev_q & ~vs_n;
    assign fade_tick = (fade_cnt_q == FADE_LAST);

    always_comb begin
        case (mcu_data)
            CMD_SCAN: cmd_kind = K_SCAN;
            CMD_VOL:  cmd_kind = K_VOL;
            CMD_HOFF: cmd_kind = K_HOFF;
            default:  cmd_kind = K_NONE;
        endcase
    end

    // A start pulse always restarts the frame; a strobe on that same cycle is the command byte.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        scan_wr    = 1'b0;
        vol_wr     = 1'b0;
        hoff_lo_wr = 1'b0;
        hoff_wr    = 1'b0;
        bad_cmd    = 1'b0;
        if (mcu_start || (mcu_strobe && state_q == S_CMD)) begin
            state_d = S_CMD;
            if (mcu_strobe) begin
                if (cmd_kind == K_NONE) begin
                    bad_cmd = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    kind_d  = cmd_kind;
                    state_d = S_PAY0;
                end
            end
        end else if (mcu_strobe) begin
            case (state_q)
                S_PAY0: begin
                    state_d = S_IDLE;
                    case (kind_q)
                        K_SCAN:  scan_wr = 1'b1;
                        K_VOL:   vol_wr  = 1'b1;
                        K_HOFF: begin
                            hoff_lo_wr = 1'b1;
                            state_d    = S_PAY1;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
                S_PAY1: begin
                    hoff_wr = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            kind_q        <= K_NONE;
            hoff_lo_q     <= 8'd0;
            scan_shadow_q <= 2'd0;
            hoff_shadow_q <= HOFF_RESET;
            vol_tgt_q     <= VOL_RESET;
            pending_q     <= 1'b0;
            vs_prev_q     <= 1'b1;
            fade_cnt_q    <= '0;
            scanlines_q   <= 2'd0;
            volume_q      <= VOL_RESET;
            h_offset_q    <= HOFF_RESET;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cmd_err_q <= bad_cmd;
            vs_prev_q <= vs_n;
            if (hoff_lo_wr) hoff_lo_q     <= mcu_data;
            if (scan_wr)    scan_shadow_q <= mcu_data[1:0];
            if (vol_wr)     vol_tgt_q     <= mcu_data[1:0];
            if (hoff_wr)    hoff_shadow_q <= {mcu_data[1:0], hoff_lo_q};

            // Commit uses the pre-edge shadows, so a same-edge write stays pending for the next vsync.
            if (vs_fall) begin
                scanlines_q <= scan_shadow_q;
                h_offset_q  <= hoff_shadow_q;
            end
            if (scan_wr || hoff_wr)
                pending_q <= 1'b1;
            else if (vs_fall)
                pending_q <= 1'b0;

            fade_cnt_q <= fade_tick ? '0 : fade_cnt_q + 1'b1;
            if (fade_tick) begin
                if (volume_q < vol_tgt_q)
                    volume_q <= volume_q + 2'd1;
                else if (volume_q > vol_tgt_q)
                    volume_q <= volume_q - 2'd1;
            end
        end
    end

    assign scanlines = scanlines_q;
    assign volume    = volume_q;
    assign h_offset  = h_offset_q;
    assign cmd_err   = cmd_err_q;
    assign busy      = (state_q != S_IDLE) | pending_q | (volume_q != vol_tgt_q);

endmodule

// File: tb/tb_video_cfg_ctrl.sv
// Directed and random bench for video_cfg_ctrl; a frame-level reference model predicts every output each cycle.
module tb_video_cfg_ctrl;

    localparam int FADE_DIV = 4;

    logic       clk = 1'b0;
    logic       resetn, mcu_start, mcu_strobe, vs_n;
    logic [7:0] mcu_data;
    logic [1:0] scanlines, volume;
    logic [9:0] h_offset;
    logic       busy, cmd_err;

    video_cfg_ctrl #(.FADE_DIV(FADE_DIV)) dut (
        .clk(clk), .resetn(resetn), .mcu_start(mcu_start), .mcu_strobe(mcu_strobe),
        .mcu_data(mcu_data), .vs_n(vs_n), .scanlines(scanlines), .volume(volume),
        .h_offset(h_offset), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bytes of the current frame are collected and interpreted once complete.
    logic [7:0] frame[$];
    bit         m_in_frame;
    logic [1:0] m_scan, m_scan_sh, m_vol, m_vol_tgt;
    logic [9:0] m_hoff, m_hoff_sh;
    bit         m_pending, m_err, m_vs_prev;
    int         m_edges;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rn, input logic st, input logic sb,
                              input logic [7:0] d, input logic v);
        bit         vs_fall, tick, pend_set;
        logic [1:0] n_scan_sh, n_tgt;
        logic [9:0] n_hoff_sh;
        logic [7:0] c;
        if (!rn) begin
            frame.delete();
            m_in_frame = 0; m_scan = 0; m_scan_sh = 0; m_vol = 2; m_vol_tgt = 2;
            m_hoff = 70; m_hoff_sh = 70; m_pending = 0; m_err = 0; m_vs_prev = 1; m_edges = 0;
            return;
        end
        vs_fall   = m_vs_prev && !v;
        tick      = (m_edges % FADE_DIV) == FADE_DIV - 1;
        n_scan_sh = m_scan_sh; n_tgt = m_vol_tgt; n_hoff_sh = m_hoff_sh;
        pend_set  = 0;
        m_err     = 0;
        if (st) begin
            frame.delete();
            m_in_frame = 1;
        end
        if (sb && m_in_frame) begin
            frame.push_back(d);
            c = frame[0];
            if (c != 8'h50 && c != 8'h51 && c != 8'h52) begin
                m_err = 1; m_in_frame = 0;
            end else if (c == 8'h50 && frame.size() == 2) begin
                n_scan_sh = d[1:0]; pend_set = 1; m_in_frame = 0;
            end else if (c == 8'h51 && frame.size() == 2) begin
                n_tgt = d[1:0]; m_in_frame = 0;
            end else if (c == 8'h52 && frame.size() == 3) begin
                n_hoff_sh = {d[1:0], frame[1]}; pend_set = 1; m_in_frame = 0;
            end
        end
        if (vs_fall) begin
            m_scan = m_scan_sh;
            m_hoff = m_hoff_sh;
        end
        if (pend_set) m_pending = 1;
        else if (vs_fall) m_pending = 0;
        if (tick) begin
            if (m_vol < m_vol_tgt) m_vol = m_vol + 2'd1;
            else if (m_vol > m_vol_tgt) m_vol = m_vol - 2'd1;
        end
        m_scan_sh = n_scan_sh; m_vol_tgt = n_tgt; m_hoff_sh = n_hoff_sh;
        m_edges++;
        m_vs_prev = v;
    endtask

    task automatic cyc(input logic rn, input logic st, input logic sb,
                       input logic [7:0] d, input logic v);
        resetn = rn; mcu_start = st; mcu_strobe = sb; mcu_data = d; vs_n = v;
        model_step(rn, st, sb, d, v);
        @(posedge clk);
        #1;
        chk("scanlines", 32'(scanlines), 32'(m_scan));
        chk("volume",    32'(volume),    32'(m_vol));
        chk("h_offset",  32'(h_offset),  32'(m_hoff));
        chk("busy",      32'(busy),      32'(m_in_frame || m_pending || (m_vol != m_vol_tgt)));
        chk("cmd_err",   32'(cmd_err),   32'(m_err));
        $display("t=%0t rn=%0b st=%0b sb=%0b d=%02h vs=%0b -> scan=%0d vol=%0d hoff=%0d busy=%0b err=%0b",
                 $time, rn, st, sb, d, v, scanlines, volume, h_offset, busy, cmd_err);
    endtask

    task automatic idle(input int n, input logic v);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 8'h00, v);
    endtask

    initial begin
        logic [7:0] d;
        logic       rn, st, sb, v;
        int         r;
        resetn = 0; mcu_start = 0; mcu_strobe = 0; mcu_data = 0; vs_n = 1;
        @(negedge clk);

        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);
        chk("rst_scan", 32'(scanlines), 0);
        chk("rst_vol",  32'(volume),    2);
        chk("rst_hoff", 32'(h_offset),  70);
        chk("rst_busy", 32'(busy),      0);
        chk("rst_err",  32'(cmd_err),   0);

        // Scanline write commits only on vsync fall
        cyc(1, 1, 0, 8'h00, 1);
        cyc(1, 0, 1, 8'h50, 1);
        cyc(1, 0, 1, 8'h03, 1);
        idle(3, 1);
        chk("scan_hold", 32'(scanlines), 0);
        chk("scan_busy", 32'(busy),      1);
        cyc(1, 0, 0, 8'h00, 0);
        chk("scan_commit", 32'(scanlines), 3);
        chk("scan_idle",   32'(busy),      0);
        idle(1, 1);

        // Horizontal offset, then an aborted offset frame
        cyc(1, 1, 0, 8'h00, 1);
        cyc(1, 0, 1, 8'h52, 1);
        cyc(1, 0, 1, 8'h34, 1);
        cyc(1, 0, 1, 8'h01, 1);
        cyc(1, 0, 0, 8'h00, 0);
        idle(1, 1);
        chk("hoff_commit", 32'(h_offset), 308);
        cyc(1, 1, 1, 8'h52, 1);
        cyc(1, 0, 1, 8'h20, 1);
        cyc(1, 1, 0, 8'h00, 1);
        cyc(1, 0, 1, 8'h50, 1);
        cyc(1, 0, 1, 8'h01, 1);
        cyc(1, 0, 0, 8'h00, 0);
        idle(1, 1);
        chk("abort_hoff", 32'(h_offset), 308);
        chk("abort_scan", 32'(scanlines), 1);

        // Volume fade down, then retarget upward after the first step
        cyc(1, 1, 0, 8'h00, 1);
        cyc(1, 0, 1, 8'h51, 1);
        cyc(1, 0, 1, 8'h00, 1);
        for (int i = 0; i < 20 && volume !== 2'd1; i++) cyc(1, 0, 0, 8'h00, 1);
        chk("fade_step1", 32'(volume), 1);
        cyc(1, 1, 1, 8'h51, 1);
        cyc(1, 0, 1, 8'h03, 1);
        idle(16, 1);
        chk("fade_up", 32'(volume), 3);
        chk("fade_done_busy", 32'(busy), 0);

        // Unknown command pulses cmd_err once; trailing byte ignored
        cyc(1, 1, 0, 8'h00, 1);
        cyc(1, 0, 1, 8'h7F, 1);
        chk("err_pulse", 32'(cmd_err), 1);
        cyc(1, 0, 1, 8'h02, 1);
        chk("err_clear", 32'(cmd_err), 0);
        cyc(1, 0, 0, 8'h00, 0);
        idle(1, 1);
        chk("err_scan", 32'(scanlines), 1);
        chk("err_hoff", 32'(h_offset),  308);
        chk("err_vol",  32'(volume),    3);

        // Shadow write coinciding with vsync fall is deferred to the next vsync
        cyc(1, 1, 1, 8'h50, 1);
        cyc(1, 0, 1, 8'h02, 0);
        chk("same_edge_scan", 32'(scanlines), 1);
        chk("same_edge_busy", 32'(busy),      1);
        cyc(1, 0, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 0);
        chk("deferred_scan", 32'(scanlines), 2);
        idle(1, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 299) != 0);
            st = ($urandom_range(0, 7) == 0);
            sb = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            case (r)
                0:       d = 8'h50;
                1:       d = 8'h51;
                2:       d = 8'h52;
                default: d = 8'($urandom_range(0, 255));
            endcase
            v = ($urandom_range(0, 15) != 0);
            cyc(rn, st, sb, d, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
